// File: rtl/numbotron_ui_pkg.sv
// Shared types and default timing for the digit-edit button front end.
// All timing values are in prescaler ticks.
package numbotron_ui_pkg;

    localparam int DEF_CNT_W               = 16;
    localparam int DEF_DEBOUNCE_TICKS      = 4;
    localparam int DEF_LONG_PRESS_TICKS    = 200;
    localparam int DEF_REPEAT_DELAY_TICKS  = 50;
    localparam int DEF_REPEAT_PERIOD_TICKS = 10;
    localparam int DEF_IDLE_TIMEOUT_TICKS  = 1000;

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_HELD = 2'd1,
        D_LONG = 2'd2
    } digit_state_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_REPEAT = 2'd2
    } sel_state_e;

endpackage

// File: rtl/edit_button_ctrl_debounce.sv
// One push-button: two-flop synchroniser, tick-based debouncer and edge strobes.
// After reset, edges stay masked until the button has been seen released.
module button_debounce
    import numbotron_ui_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

    logic [1:0]       sync_q;
    logic [1:0]       vld_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             armed_q, armed_d;

    assign cnt_inc_s = (cnt_q == MAX_C) ? cnt_q : cnt_q + ONE_C;

    // Debounce next-state; vld_q marks when sync_q[1] reflects the real pin
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        armed_d  = armed_q | (vld_q[1] & ~sync_q[1] & ~stable_q);
        if (sync_q[1] == stable_q) begin
            cnt_d = ZERO_C;
        end else if (tick_i && (cnt_inc_s == DEB_C)) begin
            cnt_d    = ZERO_C;
            stable_d = sync_q[1];
            rise_d   = sync_q[1] & armed_q;
            fall_d   = ~sync_q[1] & armed_q;
        end else if (tick_i) begin
            cnt_d = cnt_inc_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchroniser, debounce state and strobe registers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b00;
            vld_q    <= 2'b00;
            cnt_q    <= ZERO_C;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_raw_i};
            vld_q    <= {vld_q[0], 1'b1};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            armed_q  <= armed_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/edit_button_ctrl.sv
// Digit-edit button front end: long-press on the digit button, auto-repeat on
// the select button, digit-over-select interlock and edit_active idle timeout.
module edit_button_ctrl
    import numbotron_ui_pkg::*;
#(
    parameter int DEBOUNCE_TICKS      = DEF_DEBOUNCE_TICKS,
    parameter int LONG_PRESS_TICKS    = DEF_LONG_PRESS_TICKS,
    parameter int REPEAT_DELAY_TICKS  = DEF_REPEAT_DELAY_TICKS,
    parameter int REPEAT_PERIOD_TICKS = DEF_REPEAT_PERIOD_TICKS,
    parameter int IDLE_TIMEOUT_TICKS  = DEF_IDLE_TIMEOUT_TICKS,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_digit_raw,
    input  logic btn_select_raw,
    output logic inc_digit,
    output logic inc_selection,
    output logic reset_digit,
    output logic edit_active
);

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_PRESS_TICKS);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY_TICKS);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD_TICKS);
    localparam logic [CNT_W-1:0] IDLE_C   = CNT_W'(IDLE_TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_C    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};

    logic d_stable_s, d_rise_s, d_fall_s;
    logic s_stable_s, s_rise_s, s_fall_s;

    digit_state_e     d_state_q, d_state_d;
    sel_state_e       s_state_q, s_state_d;
    logic [CNT_W-1:0] hold_q, hold_d, hold_inc_s;
    logic [CNT_W-1:0] rep_q, rep_d, rep_inc_s;
    logic [CNT_W-1:0] idle_q, idle_d, idle_inc_s;
    logic             inc_digit_q, inc_digit_d;
    logic             reset_digit_q, reset_digit_d;
    logic             inc_selection_q, inc_selection_d;
    logic             edit_active_q, edit_active_d;
    logic             sel_pulse_s, any_pulse_s;

    button_debounce #(.CNT_W(CNT_W), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_digit_db (
        .clk(clk), .reset(reset), .tick_i(tick), .btn_raw_i(btn_digit_raw),
        .stable_o(d_stable_s), .rise_o(d_rise_s), .fall_o(d_fall_s)
    );

    button_debounce #(.CNT_W(CNT_W), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_select_db (
        .clk(clk), .reset(reset), .tick_i(tick), .btn_raw_i(btn_select_raw),
        .stable_o(s_stable_s), .rise_o(s_rise_s), .fall_o(s_fall_s)
    );

    assign hold_inc_s = (hold_q == MAX_C) ? hold_q : hold_q + ONE_C;
    assign rep_inc_s  = (rep_q  == MAX_C) ? rep_q  : rep_q  + ONE_C;
    assign idle_inc_s = (idle_q == MAX_C) ? idle_q : idle_q + ONE_C;

    // Digit FSM: short press acts on release, long press fires once while held
    always_comb begin
        d_state_d     = d_state_q;
        hold_d        = hold_q;
        inc_digit_d   = 1'b0;
        reset_digit_d = 1'b0;
        case (d_state_q)
            D_IDLE: begin
                if (d_rise_s) begin
                    d_state_d = D_HELD;
                    hold_d    = ZERO_C;
                end else begin
                    d_state_d = D_IDLE;
                end
            end
            D_HELD: begin
                if (d_fall_s) begin
                    inc_digit_d = 1'b1;
                    d_state_d   = D_IDLE;
                end else if (tick && (hold_inc_s == LONG_C)) begin
                    reset_digit_d = 1'b1;
                    hold_d        = hold_inc_s;
                    d_state_d     = D_LONG;
                end else if (tick) begin
                    hold_d = hold_inc_s;
                end else begin
                    hold_d = hold_q;
                end
            end
            D_LONG: begin
                if (d_fall_s) begin
                    d_state_d = D_IDLE;
                end else begin
                    d_state_d = D_LONG;
                end
            end
            default: begin
                d_state_d = D_IDLE;
                hold_d    = ZERO_C;
            end
        endcase
    end

    // Select FSM: pulse on press, after the repeat delay, then every period
    always_comb begin
        s_state_d   = s_state_q;
        rep_d       = rep_q;
        sel_pulse_s = 1'b0;
        case (s_state_q)
            S_IDLE: begin
                if (s_rise_s) begin
                    sel_pulse_s = 1'b1;
                    s_state_d   = S_FIRST;
                    rep_d       = ZERO_C;
                end else begin
                    s_state_d = S_IDLE;
                end
            end
            S_FIRST: begin
                if (s_fall_s) begin
                    s_state_d = S_IDLE;
                end else if (tick && (rep_inc_s == DELAY_C)) begin
                    sel_pulse_s = 1'b1;
                    s_state_d   = S_REPEAT;
                    rep_d       = ZERO_C;
                end else if (tick) begin
                    rep_d = rep_inc_s;
                end else begin
                    rep_d = rep_q;
                end
            end
            S_REPEAT: begin
                if (s_fall_s) begin
                    s_state_d = S_IDLE;
                end else if (tick && (rep_inc_s == PERIOD_C)) begin
                    sel_pulse_s = 1'b1;
                    rep_d       = ZERO_C;
                end else if (tick) begin
                    rep_d = rep_inc_s;
                end else begin
                    rep_d = rep_q;
                end
            end
            default: begin
                s_state_d = S_IDLE;
                rep_d     = ZERO_C;
            end
        endcase
    end

    // Interlock and idle timer; the last term keeps a 1-tick repeat from doubling up
    always_comb begin
        inc_selection_d = sel_pulse_s & ~d_stable_s & ~d_rise_s & ~inc_selection_q;
        any_pulse_s     = inc_digit_d | reset_digit_d | inc_selection_d;
        idle_d          = idle_q;
        edit_active_d   = edit_active_q;
        if (any_pulse_s) begin
            idle_d        = ZERO_C;
            edit_active_d = 1'b1;
        end else if (d_stable_s || s_stable_s) begin
            idle_d = ZERO_C;
        end else if (tick && (idle_q != IDLE_C)) begin
            idle_d        = idle_inc_s;
            edit_active_d = (idle_inc_s == IDLE_C) ? 1'b0 : edit_active_q;
        end else begin
            idle_d = idle_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            d_state_q       <= D_IDLE;
            s_state_q       <= S_IDLE;
            hold_q          <= ZERO_C;
            rep_q           <= ZERO_C;
            idle_q          <= ZERO_C;
            inc_digit_q     <= 1'b0;
            reset_digit_q   <= 1'b0;
            inc_selection_q <= 1'b0;
            edit_active_q   <= 1'b0;
        end else begin
            d_state_q       <= d_state_d;
            s_state_q       <= s_state_d;
            hold_q          <= hold_d;
            rep_q           <= rep_d;
            idle_q          <= idle_d;
            inc_digit_q     <= inc_digit_d;
            reset_digit_q   <= reset_digit_d;
            inc_selection_q <= inc_selection_d;
            edit_active_q   <= edit_active_d;
        end
    end

    assign inc_digit     = inc_digit_q;
    assign reset_digit   = reset_digit_q;
    assign inc_selection = inc_selection_q;
    assign edit_active   = edit_active_q;

endmodule

// File: tb/tb_edit_button_ctrl.sv
// Self-checking bench for edit_button_ctrl: directed scenarios followed by
// randomized button/tick/reset activity, checked every cycle against a reference model.
module tb_edit_button_ctrl;

    localparam int DEB    = 4;
    localparam int LONG   = 20;
    localparam int DELAY  = 8;
    localparam int PERIOD = 3;
    localparam int IDLE   = 30;

    logic clk = 1'b0;
    logic reset, tick, btn_digit_raw, btn_select_raw;
    logic inc_digit, inc_selection, reset_digit, edit_active;

    int checks = 0;
    int failures = 0;
    int n_inc_d, n_inc_s, n_rst_d;

    edit_button_ctrl #(
        .DEBOUNCE_TICKS(DEB), .LONG_PRESS_TICKS(LONG), .REPEAT_DELAY_TICKS(DELAY),
        .REPEAT_PERIOD_TICKS(PERIOD), .IDLE_TIMEOUT_TICKS(IDLE), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_digit_raw(btn_digit_raw), .btn_select_raw(btn_select_raw),
        .inc_digit(inc_digit), .inc_selection(inc_selection),
        .reset_digit(reset_digit), .edit_active(edit_active)
    );

    always #5 clk = ~clk;

    // Reference model. Index 0 = digit button, 1 = select button.
    // A button's view is: raw pin delayed two clks, accepted after DEB consecutive
    // mismatching ticks. Press actions are expressed in ticks since the accepted press.
    int m_p1[2], m_p2[2], m_age[2], m_lvl[2], m_run[2], m_up[2], m_dn[2], m_ok[2];
    int m_dpress, m_dticks, m_dlong;
    int m_spress, m_sticks;
    int m_quiet, m_act;
    int e_inc_d, e_inc_s, e_rst_d;

    always @(posedge clk) begin
        int raw [2];
        int pd, ps, pr, sp, seen, next_ok;
        raw[0] = btn_digit_raw;
        raw[1] = btn_select_raw;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_p1[b] = 0; m_p2[b] = 0; m_age[b] = 0; m_lvl[b] = 0;
                m_run[b] = 0; m_up[b] = 0; m_dn[b] = 0; m_ok[b] = 0;
            end
            m_dpress = 0; m_dticks = 0; m_dlong = 0;
            m_spress = 0; m_sticks = 0;
            m_quiet = 0; m_act = 0;
            e_inc_d = 0; e_inc_s = 0; e_rst_d = 0;
        end else begin
            pd = 0; pr = 0; sp = 0;
            if (m_dpress != 0) begin
                if (m_dn[0] != 0) begin
                    if (m_dlong == 0) pd = 1;
                    m_dpress = 0;
                end else if (tick && m_dlong == 0) begin
                    m_dticks++;
                    if (m_dticks == LONG) begin
                        pr = 1;
                        m_dlong = 1;
                    end
                end
            end else if (m_up[0] != 0) begin
                m_dpress = 1; m_dticks = 0; m_dlong = 0;
            end
            if (m_spress != 0) begin
                if (m_dn[1] != 0) begin
                    m_spress = 0;
                end else if (tick) begin
                    m_sticks++;
                    if (m_sticks == DELAY || (m_sticks > DELAY && (m_sticks - DELAY) % PERIOD == 0))
                        sp = 1;
                end
            end else if (m_up[1] != 0) begin
                sp = 1; m_spress = 1; m_sticks = 0;
            end
            ps = (sp != 0 && m_lvl[0] == 0 && m_up[0] == 0) ? 1 : 0;
            if (pd != 0 || ps != 0 || pr != 0) begin
                m_quiet = 0;
                m_act = 1;
            end else if (m_lvl[0] != 0 || m_lvl[1] != 0) begin
                m_quiet = 0;
            end else if (tick && m_quiet < IDLE) begin
                m_quiet++;
                if (m_quiet == IDLE) m_act = 0;
            end
            for (int b = 0; b < 2; b++) begin
                seen = m_p2[b];
                next_ok = (m_ok[b] != 0 || (m_age[b] >= 2 && seen == 0 && m_lvl[b] == 0)) ? 1 : 0;
                m_up[b] = 0;
                m_dn[b] = 0;
                if (seen == m_lvl[b]) begin
                    m_run[b] = 0;
                end else if (tick) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_lvl[b] = seen;
                        m_run[b] = 0;
                        if (m_ok[b] != 0) begin
                            m_up[b] = seen;
                            m_dn[b] = 1 - seen;
                        end
                    end
                end
                m_ok[b] = next_ok;
                m_p2[b] = m_p1[b];
                m_p1[b] = raw[b];
                if (m_age[b] < 2) m_age[b]++;
            end
            e_inc_d = pd; e_inc_s = ps; e_rst_d = pr;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr_counts();
        n_inc_d = 0; n_inc_s = 0; n_rst_d = 0;
    endtask

    // Advance n clks; outputs compared against the model on each falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_eq("inc_digit", inc_digit, e_inc_d);
            chk_eq("inc_selection", inc_selection, e_inc_s);
            chk_eq("reset_digit", reset_digit, e_rst_d);
            chk_eq("edit_active", edit_active, m_act);
            n_inc_d += int'(inc_digit);
            n_inc_s += int'(inc_selection);
            n_rst_d += int'(reset_digit);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b1; btn_digit_raw = 1'b0; btn_select_raw = 1'b0;
        clr_counts();
        step(3);
        chk_eq("reset_edit_active", edit_active, 32'd0);
        reset = 1'b0;
        step(5);

        // Bouncing select button never settles long enough
        clr_counts();
        for (int i = 0; i < 10; i++) begin
            btn_select_raw = 1'b1; step(2);
            btn_select_raw = 1'b0; step(2);
        end
        step(20);
        chk_eq("bounce_pulses", n_inc_d + n_inc_s + n_rst_d, 32'd0);
        chk_eq("bounce_active", edit_active, 32'd0);

        // Short digit press acts on release only
        clr_counts();
        btn_digit_raw = 1'b1; step(10);
        chk_eq("short_during_press", n_inc_d, 32'd0);
        btn_digit_raw = 1'b0; step(15);
        chk_eq("short_inc_digit", n_inc_d, 32'd1);
        chk_eq("short_reset_digit", n_rst_d, 32'd0);
        chk_eq("short_active", edit_active, 32'd1);

        // Long digit press: one reset_digit, nothing on release
        clr_counts();
        btn_digit_raw = 1'b1; step(26);
        chk_eq("long_not_yet", n_rst_d, 32'd0);
        step(1);
        chk_eq("long_at_27", n_rst_d, 32'd1);
        step(13);
        btn_digit_raw = 1'b0; step(15);
        chk_eq("long_reset_digit", n_rst_d, 32'd1);
        chk_eq("long_inc_digit", n_inc_d, 32'd0);

        // Auto-repeat: clks 7, 15, 18, ... 36 after press (release seen at 36)
        clr_counts();
        btn_select_raw = 1'b1; step(30);
        chk_eq("repeat_while_held", n_inc_s, 32'd7);
        btn_select_raw = 1'b0; step(15);
        chk_eq("repeat_total", n_inc_s, 32'd9);

        // Interlock: select press while digit held yields no inc_selection
        clr_counts();
        btn_digit_raw = 1'b1; step(10);
        btn_select_raw = 1'b1; step(20);
        btn_select_raw = 1'b0; step(10);
        btn_digit_raw = 1'b0; step(15);
        chk_eq("interlock_inc_sel", n_inc_s, 32'd0);

        // Idle timeout
        step(45);
        chk_eq("idle_timeout", edit_active, 32'd0);

        // Reset mid-repeat with the button still held
        clr_counts();
        btn_select_raw = 1'b1; step(20);
        reset = 1'b1; step(1);
        chk_eq("midreset_inc_sel", inc_selection, 32'd0);
        chk_eq("midreset_active", edit_active, 32'd0);
        reset = 1'b0;
        clr_counts();
        step(30);
        chk_eq("held_after_reset", n_inc_s, 32'd0);
        btn_select_raw = 1'b0; step(12);
        chk_eq("release_after_reset", n_inc_s, 32'd0);
        btn_select_raw = 1'b1; step(10);
        btn_select_raw = 1'b0; step(12);
        chk_eq("fresh_press", n_inc_s, 32'd2);

        // Randomized buttons, tick gaps and occasional reset
        for (int i = 0; i < 4000; i++) begin
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) btn_digit_raw = ~btn_digit_raw;
            if ($urandom_range(0, 17) == 0) btn_select_raw = ~btn_select_raw;
            reset = ($urandom_range(0, 599) == 0);
            step(1);
        end
        reset = 1'b0; tick = 1'b1;
        btn_digit_raw = 1'b0; btn_select_raw = 1'b0;
        step(60);
        chk_eq("final_active", edit_active, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
